// File: rtl/bin2rns_pkg.sv
// Shared types and constants for the sequential binary-to-RNS converter.
package bin2rns_pkg;

  // Converter phases; the encoding is visible on the state_dbg port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Smallest modulus that yields a meaningful residue.
  localparam int MOD_MIN = 2;

  // Default residue/modulus width and the matching channel types.
  localparam int DEF_MOD_W = 4;
  typedef logic [DEF_MOD_W-1:0] residue_t;
  typedef logic [DEF_MOD_W-1:0] modulus_t;

endpackage

// File: rtl/rns_mod_step.sv
// One MSB-first Horner step for a single RNS channel: r' = (2*r + bit) mod m.
// Because r < m holds on entry, 2*r + bit < 2*m, so a single conditional
// subtract brings the value back into range.
module rns_mod_step #(
  parameter int MOD_W = 4
) (
  input  logic [MOD_W-1:0] r,
  input  logic             bit_in,
  input  logic [MOD_W-1:0] m,
  output logic [MOD_W-1:0] r_next
);

  logic [MOD_W:0] t;
  logic [MOD_W:0] diff;

  // Double-and-add, then reduce once.
  always_comb begin
    t      = {r, bit_in};
    diff   = t - {1'b0, m};
    r_next = (t >= {1'b0, m}) ? diff[MOD_W-1:0] : t[MOD_W-1:0];
  end

endmodule

// File: rtl/bin2rns_seq.sv
// Sequential binary-to-RNS converter: one operand bit per cycle, all
// NUM_MOD channels in parallel. Optional feature macro: BIN2RNS_SIGNED_EN
// (operand treated as two's complement; negatives are fixed up after CONV).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and res_out/mod_err stay stable there until out_ready is seen.
module bin2rns_seq
  import bin2rns_pkg::*;
#(
  parameter int N_W     = 32,
  parameter int NUM_MOD = 4,
  parameter int MOD_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_W-1:0]           n,
  input  logic [NUM_MOD*MOD_W-1:0] mod_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_MOD*MOD_W-1:0] res_out,
  output logic                     mod_err,
  output state_t                   state_dbg
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [N_W-1:0]             sh_q;
  logic [NUM_MOD*MOD_W-1:0]   mod_q;
  logic [NUM_MOD*MOD_W-1:0]   r_q;
  logic [NUM_MOD*MOD_W-1:0]   r_step;
  logic [NUM_MOD*MOD_W-1:0]   r_fix;
  logic                       sign_q;
  logic                       err_q;
  logic                       sign_in;
  logic                       err_in;
  logic [N_W-1:0]             mag;

`ifdef BIN2RNS_SIGNED_EN
  // Two's-complement operand: reduce |n| and negate the residues afterwards.
  // The magnitude is N_W bits unsigned, so the most negative value fits.
  always_comb begin
    sign_in = n[N_W-1];
    mag     = sign_in ? (~n + 1'b1) : n;
  end
`else
  // Unsigned operand: reduced as-is, FIX leaves residues untouched.
  always_comb begin
    sign_in = 1'b0;
    mag     = n;
  end
`endif

  // Flag any modulus too small to define a residue.
  always_comb begin
    err_in = 1'b0;
    for (int k = 0; k < NUM_MOD; k++) begin
      if (mod_in[k*MOD_W +: MOD_W] < MOD_W'(MOD_MIN)) err_in = 1'b1;
    end
  end

  // One Horner step per channel, all fed by the current operand MSB.
  for (genvar k = 0; k < NUM_MOD; k++) begin : g_step
    rns_mod_step #(.MOD_W(MOD_W)) u_step (
      .r      (r_q[k*MOD_W +: MOD_W]),
      .bit_in (sh_q[N_W-1]),
      .m      (mod_q[k*MOD_W +: MOD_W]),
      .r_next (r_step[k*MOD_W +: MOD_W])
    );
  end

  // Final correction: zero bad channels, map r to m-r for negative operands.
  always_comb begin
    logic [MOD_W-1:0] mk;
    logic [MOD_W-1:0] rk;
    r_fix = '0;
    mk    = '0;
    rk    = '0;
    for (int k = 0; k < NUM_MOD; k++) begin
      mk = mod_q[k*MOD_W +: MOD_W];
      rk = r_q[k*MOD_W +: MOD_W];
      if (mk < MOD_W'(MOD_MIN))
        r_fix[k*MOD_W +: MOD_W] = '0;
      else if (sign_q && (rk != '0))
        r_fix[k*MOD_W +: MOD_W] = mk - rk;
      else
        r_fix[k*MOD_W +: MOD_W] = rk;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch on accept, step during CONV, correct during FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      mod_q  <= '0;
      r_q    <= '0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q   <= mag;
            mod_q  <= mod_in;
            sign_q <= sign_in;
            err_q  <= err_in;
            r_q    <= '0;
            cnt_q  <= CNT_W'(N_W - 1);
          end
        end
        CONV: begin
          r_q   <= r_step;
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          r_q <= r_fix;
        end
        default: ;
      endcase
    end
  end

  assign res_out   = r_q;
  assign mod_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bin2rns_seq.sv
// Bench for bin2rns_seq: directed vectors plus a sweep checked by a queue
// scoreboard. Signed vectors are selected with BIN2RNS_SIGNED_EN.
module tb_bin2rns_seq;
  import bin2rns_pkg::*;

  localparam int N_W     = 32;
  localparam int NUM_MOD = 4;
  localparam int MOD_W   = 4;
  localparam int W       = NUM_MOD*MOD_W + 1;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_W-1:0]           n;
  logic [NUM_MOD*MOD_W-1:0] mod_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_MOD*MOD_W-1:0] res_out;
  logic                     mod_err;
  state_t                   state_dbg;

  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  bin2rns_seq #(.N_W(N_W), .NUM_MOD(NUM_MOD), .MOD_W(MOD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .mod_in    (mod_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out),
    .mod_err   (mod_err),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pack4(input int c0, input int c1, input int c2, input int c3);
    pack4 = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endfunction

  // Reference: ((n % m) + m) % m on a 64-bit value; bad moduli give 0 and set the error.
  function automatic logic [W-1:0] model(input logic [31:0] nv, input logic [15:0] mods);
    longint sv, m, rk;
    logic [15:0] r;
    logic e;
    r = '0;
    e = 1'b0;
`ifdef BIN2RNS_SIGNED_EN
    sv = longint'($signed(nv));
`else
    sv = longint'({32'b0, nv});
`endif
    for (int k = 0; k < NUM_MOD; k++) begin
      m = longint'(mods[k*4 +: 4]);
      if (m < 2) begin
        e = 1'b1;
      end else begin
        rk = ((sv % m) + m) % m;
        r[k*4 +: 4] = rk[3:0];
      end
    end
    model = {e, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: called at posedge+1; waits for in_ready, presents one operand for one edge.
  task automatic send(input logic [31:0] nv, input logic [15:0] mods,
                      input logic [W-1:0] exp, input bit push);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) check("send_timeout", 64'(w), 64'(0));
    in_valid = 1'b1;
    n        = nv;
    mod_in   = mods;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n        = $urandom();
    mod_in   = '0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_out_valid(output int cnt);
    cnt = 1;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // Monitor / scoreboard: compare every accepted output against the queue head.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'({mod_err, res_out}), 64'(0));
        if ({mod_err, res_out} == '0) begin
          pass_cnt--;
          $display("FAIL unexpected_output: got output with empty queue, expected none");
        end
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({mod_err, res_out}), 64'(e));
      end
    end
  end

  logic [15:0] std_mods;
  int lat;

  initial begin
    std_mods  = pack4(8, 7, 5, 3);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = '0;
    mod_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_res_out",   64'(res_out),   64'(0));
    check("rst_mod_err",   64'(mod_err),   64'(0));
    check("rst_state",     64'(state_dbg), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic conversion and accept-to-valid latency.
    send(419, std_mods, {1'b0, pack4(3, 6, 4, 2)}, 1'b1);
    wait_out_valid(lat);
    check("latency", 64'(lat), 64'(N_W + 2));
    wait_drain();

    // Negative / wrap-around operands.
`ifdef BIN2RNS_SIGNED_EN
    send(-420,          std_mods, {1'b0, pack4(4, 0, 0, 0)}, 1'b1);
    send(-1,            std_mods, {1'b0, pack4(7, 6, 4, 2)}, 1'b1);
    send(32'h8000_0000, std_mods, {1'b0, pack4(0, 5, 2, 1)}, 1'b1);
`else
    send(-420,          std_mods, {1'b0, pack4(4, 4, 1, 1)}, 1'b1);
    send(-1,            std_mods, {1'b0, pack4(7, 3, 0, 0)}, 1'b1);
    send(32'h8000_0000, std_mods, {1'b0, pack4(0, 2, 3, 2)}, 1'b1);
`endif
    wait_drain();

    // Sweep against the reference model.
    for (int i = -420; i <= 419; i++) begin
      send(32'(i), std_mods, model(32'(i), std_mods), 1'b1);
    end
    wait_drain();

    // Back-pressure: result must hold and new input must be refused.
    out_ready = 1'b0;
    send(419, std_mods, {1'b0, pack4(3, 6, 4, 2)}, 1'b1);
    wait_out_valid(lat);
    check("stall_valid", 64'(out_valid), 64'(1));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      n        = 7;
      mod_in   = std_mods;
      @(negedge clk);
      check("stall_res",      64'(res_out),   64'(pack4(3, 6, 4, 2)));
      check("stall_in_ready", 64'(in_ready),  64'(0));
      check("stall_out_vld",  64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle", 64'(state_dbg), 64'(IDLE));
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    check("no_extra_out", 64'(out_valid), 64'(0));

    // Bad modulus: flag set, that channel forced to 0.
    send(419, pack4(8, 1, 5, 3), {1'b1, pack4(3, 0, 4, 2)}, 1'b1);
    wait_drain();

    // Reset during CONV at bit 10 aborts the conversion.
    send(419, std_mods, '0, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    check("pre_rst_state", 64'(state_dbg), 64'(CONV));
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready",  64'(in_ready),  64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(5, std_mods, {1'b0, pack4(5, 5, 0, 2)}, 1'b1);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
